fpu_op_sequencer: RTL and testbench
===================================

# fpu_op_sequencer

Issue/completion controller sitting between the CPU execute stage and the FloatingPointUnit datapath. Accepts one FP operation per valid/ready handshake, holds operands and opcode stable on the FPU inputs for the operation's fixed pipeline latency, then captures the selected result and presents it on a valid/ready response channel. Only one operation is in flight at a time. Supports flush (pipeline squash) and reports illegal opcodes.

## Interface
Parameters (legal range 1..63 each):
- LAT_ADD, 7, cycles for ADD/SUB result to settle
- LAT_MULT, 5, cycles for MULT
- LAT_DIV, 28, cycles for DIV
- LAT_FTOI, 6, cycles for FTOI
- LAT_ITOF, 6, cycles for ITOF
- LAT_SQRT, 28, cycles for SQRT

Ports:
- iClk  in  1  clock, all state on rising edge
- iRst_n  in  1  asynchronous, active-low reset
- iReqValid  in  1  request present
- oReqReady  out  1  sequencer can accept request
- iReqOp  in  3  opcode (ADD=0, SUB=1, MULT=2, DIV=3, FTOI=4, ITOF=5, SQRT=6)
- iReqSrc0, iReqSrc1  in  32  operands
- iFlush  in  1  abort in-flight/pending op, no response
- oRespValid  out  1  result available
- iRespReady  in  1  consumer takes result
- oRespResult  out  32  captured result
- oRespErr  out  1  op was illegal (7)
- oBusy  out  1  state != IDLE
- oFpuSrc0, oFpuSrc1  out  32  to FPU iSrc0/iSrc1
- oFpuOp  out  3  to FPU iOperation
- iFpuResult  in  32  from FPU oResult

## Operation
- States: IDLE, BUSY, DONE. Registers: op, src0, src1, 6-bit down counter cnt, result, err.
- oReqReady = ~iFlush & (IDLE | (DONE & iRespReady)) — combinational.
- Accept = iReqValid & oReqReady. On accept: latch op/srcs, cnt ← LAT(op), err ← 0, state ← BUSY.
- Opcode 7 on accept: cnt ← 1, err ← 1; completes with result 32'h0.
- BUSY: cnt decrements each edge; at edge where cnt==1: result ← (err ? 0 : iFpuResult), state ← DONE.
- DONE: oRespValid=1, result/err held stable until iRespReady. If iRespReady & no new accept → IDLE; with simultaneous accept → BUSY with new op (back-to-back).
- oFpuSrc0/1, oFpuOp driven from latched registers; unchanged throughout BUSY and DONE.
- iFlush (any state): next state IDLE, oRespValid drops next cycle, result discarded; flush beats any accept same cycle.
- iRespReady ignored outside DONE; iReqValid ignored when oReqReady=0 (requester must hold).

## Timing
- Reset (async assert, sync release): state IDLE, cnt 0, all registered outputs 0 (oRespValid, oRespErr, oRespResult, oBusy, oFpuSrc0/1, oFpuOp); oReqReady = 1 when iFlush=0.
- Accept at edge E0 → operands on FPU from E0; result sampled at edge E_LAT; oRespValid high from E_LAT, i.e. latency = LAT(op) cycles after accept edge.
- Throughput: one op per LAT+1 cycles when consumer always ready (accept overlaps DONE cycle).
- LAT=1: BUSY lasts exactly one cycle.
- Reset mid-BUSY/DONE: op lost, no response after release.

## Structure
- Shared package fpu_pkg: opcode localparams (ADD..SQRT, ILLEGAL=7), state enum encoding, default latency constants, counter width 6.
- One sub-module natural: fpu_latency_lut (combinational opcode → 6-bit latency, parameterised by LAT_*; 7 → 1).
- Sequencer instantiates no FPU; integration wires oFpu*/iFpuResult to FloatingPointUnit.

## Test plan
- ADD 0x3F800000 + 0x40000000, iRespReady=1 → oRespValid exactly 7 cycles after accept, oRespResult 0x40400000, oRespErr 0.
- DIV 0x41200000 / 0x40000000, iRespReady held 0 for 5 cycles after valid → result 0x40A00000 held stable, oReqReady 0 until iRespReady, then drops valid.
- Back-to-back: MULT 0x40000000*0x40400000 then SQRT 0x41800000 offered in DONE cycle with iRespReady=1 → 0x40C00000 then 0x40800000 28 cycles later, no idle gap.
- Opcode 7 → oRespValid after 1 cycle, oRespErr 1, oRespResult 0.
- iFlush at cycle 10 of a DIV → IDLE next cycle, no oRespValid ever; concurrent iReqValid not accepted that cycle, accepted next.
- iRst_n pulsed low mid-SQRT (async, off clock edge) → all outputs 0 immediately, oReqReady 1, no stale response after release.

Source files
------------

// File: rtl/fpu_op_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// fpu_op_sequencer_pkg
// Shared definitions for the FPU issue/completion sequencer: opcode encoding,
// sequencer state encoding, default per-opcode latencies and counter width.
// ---------------------------------------------------------------------------
package fpu_op_sequencer_pkg;

  // Latency counter width; every latency parameter must fit in 1..63.
  localparam int unsigned CNT_W = 6;

  typedef logic [2:0] fpu_op_t;

  localparam fpu_op_t OP_ADD     = 3'd0;
  localparam fpu_op_t OP_SUB     = 3'd1;
  localparam fpu_op_t OP_MULT    = 3'd2;
  localparam fpu_op_t OP_DIV     = 3'd3;
  localparam fpu_op_t OP_FTOI    = 3'd4;
  localparam fpu_op_t OP_ITOF    = 3'd5;
  localparam fpu_op_t OP_SQRT    = 3'd6;
  localparam fpu_op_t OP_ILLEGAL = 3'd7;

  // Default settle latencies of the FloatingPointUnit datapath, in cycles.
  localparam int unsigned LAT_ADD_DEF  = 7;
  localparam int unsigned LAT_MULT_DEF = 5;
  localparam int unsigned LAT_DIV_DEF  = 28;
  localparam int unsigned LAT_FTOI_DEF = 6;
  localparam int unsigned LAT_ITOF_DEF = 6;
  localparam int unsigned LAT_SQRT_DEF = 28;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  function automatic logic is_illegal(fpu_op_t op);
    return op == OP_ILLEGAL;
  endfunction

endpackage

// File: rtl/fpu_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// fpu_op_sequencer_if
// Request/response handshake bundle between the CPU execute stage and the
// FPU sequencer.
//   Request : iReqValid / oReqReady, iReqOp, iReqSrc0, iReqSrc1, iFlush
//   Response: oRespValid / iRespReady, oRespResult, oRespErr
// Signal names keep the sequencer's point of view (i* = into sequencer).
//   master : execute stage (drives requests, consumes responses)
//   slave  : the sequencer
// ---------------------------------------------------------------------------
interface fpu_op_sequencer_if;
  import fpu_op_sequencer_pkg::*;

  logic        iReqValid;
  logic        oReqReady;
  fpu_op_t     iReqOp;
  logic [31:0] iReqSrc0;
  logic [31:0] iReqSrc1;
  logic        iFlush;
  logic        oRespValid;
  logic        iRespReady;
  logic [31:0] oRespResult;
  logic        oRespErr;

  modport master (
    output iReqValid, iReqOp, iReqSrc0, iReqSrc1, iFlush, iRespReady,
    input  oReqReady, oRespValid, oRespResult, oRespErr
  );

  modport slave (
    input  iReqValid, iReqOp, iReqSrc0, iReqSrc1, iFlush, iRespReady,
    output oReqReady, oRespValid, oRespResult, oRespErr
  );

endinterface

// File: rtl/fpu_op_sequencer_latency_lut.sv
// ---------------------------------------------------------------------------
// fpu_op_sequencer_latency_lut
// Combinational opcode -> pipeline latency lookup. ADD and SUB share the adder
// latency; the illegal opcode maps to 1 so it completes after a single cycle.
//   op_i  : opcode
//   lat_o : latency in cycles (CNT_W bits)
// ---------------------------------------------------------------------------
module fpu_op_sequencer_latency_lut
  import fpu_op_sequencer_pkg::*;
#(
  parameter int unsigned LAT_ADD  = LAT_ADD_DEF,
  parameter int unsigned LAT_MULT = LAT_MULT_DEF,
  parameter int unsigned LAT_DIV  = LAT_DIV_DEF,
  parameter int unsigned LAT_FTOI = LAT_FTOI_DEF,
  parameter int unsigned LAT_ITOF = LAT_ITOF_DEF,
  parameter int unsigned LAT_SQRT = LAT_SQRT_DEF
) (
  input  fpu_op_t          op_i,
  output logic [CNT_W-1:0] lat_o
);

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no
    // latch is inferred even if an opcode is left out of the case.
    lat_o = CNT_W'(1);
    case (op_i)
      OP_ADD, OP_SUB: lat_o = CNT_W'(LAT_ADD);
      OP_MULT:        lat_o = CNT_W'(LAT_MULT);
      OP_DIV:         lat_o = CNT_W'(LAT_DIV);
      OP_FTOI:        lat_o = CNT_W'(LAT_FTOI);
      OP_ITOF:        lat_o = CNT_W'(LAT_ITOF);
      OP_SQRT:        lat_o = CNT_W'(LAT_SQRT);
      default:        lat_o = CNT_W'(1);
    endcase
  end

endmodule

// File: rtl/fpu_op_sequencer.sv
// ---------------------------------------------------------------------------
// fpu_op_sequencer
// Issue/completion controller in front of the FloatingPointUnit datapath.
// Accepts one operation at a time, holds opcode/operands stable on the FPU
// inputs for the opcode's fixed latency, captures the result and offers it on
// a valid/ready response channel. Flush squashes the in-flight or pending op.
//   iClk, iRst_n : clock, asynchronous active-low reset
//   bus          : request/response handshake (slave side)
//   oBusy        : any operation in flight or waiting to be consumed
//   oFpuSrc0/1   : operands to FPU iSrc0/iSrc1
//   oFpuOp       : opcode to FPU iOperation
//   iFpuResult   : FPU oResult
// ---------------------------------------------------------------------------
module fpu_op_sequencer
  import fpu_op_sequencer_pkg::*;
#(
  parameter int unsigned LAT_ADD  = LAT_ADD_DEF,
  parameter int unsigned LAT_MULT = LAT_MULT_DEF,
  parameter int unsigned LAT_DIV  = LAT_DIV_DEF,
  parameter int unsigned LAT_FTOI = LAT_FTOI_DEF,
  parameter int unsigned LAT_ITOF = LAT_ITOF_DEF,
  parameter int unsigned LAT_SQRT = LAT_SQRT_DEF
) (
  input  logic              iClk,
  input  logic              iRst_n,
  fpu_op_sequencer_if.slave bus,
  output logic              oBusy,
  output logic [31:0]       oFpuSrc0,
  output logic [31:0]       oFpuSrc1,
  output fpu_op_t           oFpuOp,
  input  logic [31:0]       iFpuResult
);

  seq_state_e       state_q,  state_d;
  fpu_op_t          op_q,     op_d;
  logic [31:0]      src0_q,   src0_d;
  logic [31:0]      src1_q,   src1_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [31:0]      result_q, result_d;
  logic             err_q,    err_d;

  logic [CNT_W-1:0] req_lat;
  logic             req_ready;
  logic             accept;

  fpu_op_sequencer_latency_lut #(
    .LAT_ADD  (LAT_ADD),
    .LAT_MULT (LAT_MULT),
    .LAT_DIV  (LAT_DIV),
    .LAT_FTOI (LAT_FTOI),
    .LAT_ITOF (LAT_ITOF),
    .LAT_SQRT (LAT_SQRT)
  ) u_lat_lut (
    .op_i  (bus.iReqOp),
    .lat_o (req_lat)
  );

  // Ready while idle, or in DONE when the consumer takes the result this same
  // cycle, which lets a new op overlap the completion cycle. Flush masks it so
  // a squash can never coincide with an accept.
  assign req_ready = ~bus.iFlush &
                     ((state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.iRespReady));
  assign accept    = bus.iReqValid & req_ready;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    src0_d   = src0_q;
    src1_d   = src1_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: ;
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        // The FPU output has settled on the edge where the count reaches 1.
        if (cnt_q == CNT_W'(1)) begin
          result_d = err_q ? 32'h0 : iFpuResult;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.iRespReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      op_d    = bus.iReqOp;
      src0_d  = bus.iReqSrc0;
      src1_d  = bus.iReqSrc1;
      cnt_d   = req_lat;
      err_d   = is_illegal(bus.iReqOp);
      state_d = ST_BUSY;
    end

    if (bus.iFlush) state_d = ST_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      src0_q   <= 32'h0;
      src1_q   <= 32'h0;
      cnt_q    <= '0;
      result_q <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      src0_q   <= src0_d;
      src1_q   <= src1_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign bus.oReqReady   = req_ready;
  assign bus.oRespValid  = (state_q == ST_DONE);
  assign bus.oRespResult = result_q;
  assign bus.oRespErr    = err_q;
  assign oBusy           = (state_q != ST_IDLE);
  assign oFpuSrc0        = src0_q;
  assign oFpuSrc1        = src1_q;
  assign oFpuOp          = op_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fpu_op_sequencer
// Self-checking bench: directed vector table, hand-written multi-cycle
// sequences and randomized traffic, all checked against a timestamp-based
// reference model. A small FPU stand-in only produces its settled result once
// the operands have been held for the opcode's latency.
// ---------------------------------------------------------------------------
module tb_fpu_op_sequencer;
  import fpu_op_sequencer_pkg::*;

  logic        iClk = 1'b0;
  logic        iRst_n = 1'b1;
  logic        busy;
  logic [31:0] fpu_src0, fpu_src1, fpu_result;
  fpu_op_t     fpu_op;

  fpu_op_sequencer_if bus ();

  fpu_op_sequencer dut (
    .iClk       (iClk),
    .iRst_n     (iRst_n),
    .bus        (bus),
    .oBusy      (busy),
    .oFpuSrc0   (fpu_src0),
    .oFpuSrc1   (fpu_src1),
    .oFpuOp     (fpu_op),
    .iFpuResult (fpu_result)
  );

  always #5 iClk = ~iClk;

  int checks = 0;
  int errors = 0;

  // Reference model state: an accepted op is visible from cycle 'due' on.
  bit          have_op = 1'b0;
  int          due = 0;
  int          cyc = 0;
  logic [2:0]  m_op;
  logic [31:0] m_s0, m_s1, m_res;
  logic        m_err;
  int          fpu_age = 0;

  function automatic int lat_of(logic [2:0] op);
    case (op)
      3'd0, 3'd1: return 7;
      3'd2:       return 5;
      3'd3:       return 28;
      3'd4, 3'd5: return 6;
      3'd6:       return 28;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [31:0] fpu_f(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    if (op == 3'd0 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (op == 3'd3 && a == 32'h41200000 && b == 32'h40000000) return 32'h40A00000;
    if (op == 3'd2 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    if (op == 3'd6 && a == 32'h41800000) return 32'h40800000;
    return a ^ {b[15:0], b[31:16]} ^ {29'd0, op} ^ 32'h5A5A0000;
  endfunction

  // FPU stand-in: garbage until the operands have been stable long enough.
  assign fpu_result = (fpu_age >= lat_of(fpu_op)) ? fpu_f(fpu_op, fpu_src0, fpu_src1)
                                                  : (32'hDEAD0000 | {29'd0, fpu_op});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h, want %h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic fl, input logic rr);
    bus.iReqValid  = v;
    bus.iReqOp     = op;
    bus.iReqSrc0   = a;
    bus.iReqSrc1   = b;
    bus.iFlush     = fl;
    bus.iRespReady = rr;
  endtask

  // One clock cycle: called at a falling edge with inputs already driven,
  // returns at the next falling edge.
  task automatic cycle();
    logic exp_valid, exp_ready, acc;
    #1;
    exp_valid = have_op && (cyc >= due);
    exp_ready = !bus.iFlush && (!have_op || (exp_valid && bus.iRespReady));
    acc       = bus.iReqValid && exp_ready;
    check("req_ready", 32'(bus.oReqReady), 32'(exp_ready));
    check("resp_valid", 32'(bus.oRespValid), 32'(exp_valid));
    check("busy", 32'(busy), 32'(have_op));
    if (exp_valid) begin
      check("resp_result", bus.oRespResult, m_res);
      check("resp_err", 32'(bus.oRespErr), 32'(m_err));
    end
    if (have_op) begin
      check("fpu_op", 32'(fpu_op), 32'(m_op));
      check("fpu_src0", fpu_src0, m_s0);
      check("fpu_src1", fpu_src1, m_s1);
    end
    @(posedge iClk);
    #1;
    cyc++;
    if (acc) fpu_age = 1;
    else if (fpu_age < 1000) fpu_age++;
    if (bus.iFlush) begin
      have_op = 1'b0;
    end else if (acc) begin
      have_op = 1'b1;
      m_op    = bus.iReqOp;
      m_s0    = bus.iReqSrc0;
      m_s1    = bus.iReqSrc1;
      m_err   = (bus.iReqOp == 3'd7);
      m_res   = m_err ? 32'h0 : fpu_f(bus.iReqOp, bus.iReqSrc0, bus.iReqSrc1);
      due     = cyc + lat_of(bus.iReqOp);
    end else if (exp_valid && bus.iRespReady) begin
      have_op = 1'b0;
    end
    @(negedge iClk);
  endtask

  // Counts edges until the DUT shows a response; bounded.
  task automatic wait_valid(output int n);
    n = 0;
    while (bus.oRespValid !== 1'b1 && n < 100) begin
      cycle();
      n++;
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] s0;
    logic [31:0] s1;
    int          hold;
    logic [31:0] exp_res;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n;

    vecs[0] = '{3'd0, 32'h3F800000, 32'h40000000, 0, 32'h40400000, 1'b0, 7};
    vecs[1] = '{3'd3, 32'h41200000, 32'h40000000, 5, 32'h40A00000, 1'b0, 28};
    vecs[2] = '{3'd7, 32'hFFFFFFFF, 32'h12345678, 0, 32'h00000000, 1'b1, 1};
    vecs[3] = '{3'd2, 32'h40000000, 32'h40400000, 2, 32'h40C00000, 1'b0, 5};
    vecs[4] = '{3'd6, 32'h41800000, 32'h00000000, 0, 32'h40800000, 1'b0, 28};

    // Reset
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2 iRst_n = 1'b0;
    @(negedge iClk);
    @(negedge iClk);
    check("rst_ready", 32'(bus.oReqReady), 32'd1);
    check("rst_valid", 32'(bus.oRespValid), 32'd0);
    check("rst_err", 32'(bus.oRespErr), 32'd0);
    check("rst_result", bus.oRespResult, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fpu_src0", fpu_src0, 32'h0);
    check("rst_fpu_src1", fpu_src1, 32'h0);
    check("rst_fpu_op", 32'(fpu_op), 32'd0);
    iRst_n = 1'b1;
    cycle();

    // Directed vector table
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].s0, vecs[i].s1, 1'b0, 1'b0);
      cycle();
      drive(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom, 1'b0, 1'b0);
      wait_valid(n);
      check($sformatf("vec%0d_latency", i), 32'(n), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_result", i), bus.oRespResult, vecs[i].exp_res);
      check($sformatf("vec%0d_err", i), 32'(bus.oRespErr), 32'(vecs[i].exp_err));
      repeat (vecs[i].hold) cycle();
      check($sformatf("vec%0d_held", i), bus.oRespResult, vecs[i].exp_res);
      bus.iRespReady = 1'b1;
      cycle();
      bus.iRespReady = 1'b0;
      check($sformatf("vec%0d_drop", i), 32'(bus.oRespValid), 32'd0);
    end

    // Back-to-back: SQRT accepted in MULT's DONE cycle
    drive(1'b1, 3'd2, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    wait_valid(n);
    check("b2b_mult_latency", 32'(n), 32'd5);
    check("b2b_mult_result", bus.oRespResult, 32'h40C00000);
    drive(1'b1, 3'd6, 32'h41800000, 32'h0, 1'b0, 1'b1);
    cycle();
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("b2b_no_gap_busy", 32'(busy), 32'd1);
    check("b2b_no_gap_valid", 32'(bus.oRespValid), 32'd0);
    wait_valid(n);
    check("b2b_sqrt_latency", 32'(n), 32'd28);
    check("b2b_sqrt_result", bus.oRespResult, 32'h40800000);
    cycle();

    // Flush at cycle 10 of a DIV with a concurrent request
    drive(1'b1, 3'd3, 32'h41200000, 32'h40000000, 1'b0, 1'b1);
    cycle();
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    repeat (9) cycle();
    drive(1'b1, 3'd0, 32'h3F800000, 32'h40000000, 1'b1, 1'b1);
    cycle();
    check("flush_idle", 32'(busy), 32'd0);
    check("flush_no_valid", 32'(bus.oRespValid), 32'd0);
    bus.iFlush = 1'b0;
    cycle();
    check("flush_next_accept", 32'(busy), 32'd1);
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    wait_valid(n);
    check("flush_add_latency", 32'(n), 32'd7);
    check("flush_add_result", bus.oRespResult, 32'h40400000);
    cycle();

    // Asynchronous reset in the middle of a SQRT
    drive(1'b1, 3'd6, 32'h41800000, 32'h0, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    repeat (10) cycle();
    #2 iRst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(bus.oRespValid), 32'd0);
    check("mid_rst_ready", 32'(bus.oReqReady), 32'd1);
    check("mid_rst_fpu_src0", fpu_src0, 32'h0);
    check("mid_rst_fpu_op", 32'(fpu_op), 32'd0);
    have_op = 1'b0;
    @(negedge iClk);
    iRst_n = 1'b1;
    repeat (40) cycle();

    // Randomized traffic against the reference model
    for (int k = 0; k < 1500; k++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
            1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 9) < 6));
      cycle();
    end
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    repeat (40) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
